// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_pkg
//  Description : Shared types and constants for the chunked add/sub sequencer
//  Revision    : 1.0  initial release
// ============================================================================
package alu_seq_pkg;

    // Sequencer state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits per nibble adder feeding one lookahead input
    localparam int NIBBLE = 4;

    // Number of chunks needed to cover the full operand width
    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/cla4_group.sv
`default_nettype none
// ============================================================================
//  Module      : cla4_group
//  Description : Combinational 4-input carry-lookahead group (nibble level)
//  Revision    : 1.0  initial release
// ============================================================================
module cla4_group (
    input  logic [3:0] i_p,     // nibble propagates, active-high
    input  logic [3:0] i_g,     // nibble generates, active-high
    input  logic       i_c,     // group carry-in
    output logic       o_c1,
    output logic       o_c2,
    output logic       o_c3,
    output logic       o_pg,    // group propagate
    output logic       o_gg,    // group generate
    output logic       o_cout   // group carry-out
);

    assign o_c1 = i_g[0] | (i_p[0] & i_c);
    assign o_c2 = i_g[1] | (i_p[1] & i_g[0]) | (i_p[1] & i_p[0] & i_c);
    assign o_c3 = i_g[2] | (i_p[2] & i_g[1]) | (i_p[2] & i_p[1] & i_g[0])
                | (i_p[2] & i_p[1] & i_p[0] & i_c);

    assign o_pg = &i_p;
    assign o_gg = i_g[3] | (i_p[3] & i_g[2]) | (i_p[3] & i_p[2] & i_g[1])
                | (i_p[3] & i_p[2] & i_p[1] & i_g[0]);

    assign o_cout = o_gg | (o_pg & i_c);

endmodule : cla4_group
`default_nettype wire

// File: rtl/alu_carry_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_carry_seq
//  Description : Multi-cycle wide add/subtract, CHUNK bits per clock through
//                one time-shared 4-nibble lookahead group
//  Revision    : 1.0  initial release
// ============================================================================
module alu_carry_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_op_sub,
    input  logic             i_cin,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_abort,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf,
    output logic             o_zero
);

    localparam int              C_NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int              C_CW     = (C_NCHUNK > 1) ? $clog2(C_NCHUNK) : 1;
    localparam logic [C_CW-1:0] C_LAST   = C_CW'(C_NCHUNK - 1);

    state_t            r_state, w_next;
    logic [WIDTH-1:0]  r_a, r_b, r_sum, w_sum_next;
    logic [C_CW-1:0]   r_cnt;
    logic              r_carry, r_busy, r_done, r_cout, r_ovf, r_zero;

    logic [CHUNK-1:0]  w_ca, w_cb, w_pb, w_gb, w_chunk_sum;
    logic [3:0]        w_p_nib, w_g_nib, w_nc;
    logic              w_c1, w_c2, w_c3, w_pg, w_gg, w_gcout, w_chain, w_cmsb;
    logic              w_last;

    // Select the operand chunk addressed by the counter and merge the new chunk result
    always_comb begin
        w_ca       = '0;
        w_cb       = '0;
        w_sum_next = r_sum;
        for (int k = 0; k < C_NCHUNK; k++) begin
            if (r_cnt == C_CW'(k)) begin
                w_ca = r_a[k*CHUNK +: CHUNK];
                w_cb = r_b[k*CHUNK +: CHUNK];
                w_sum_next[k*CHUNK +: CHUNK] = w_chunk_sum;
            end
        end
    end

    assign w_pb = w_ca ^ w_cb;
    assign w_gb = w_ca & w_cb;

    assign w_nc = {w_c3, w_c2, w_c1, r_carry};

    // Inline nibble adders: nibble P/G for the lookahead, sum bits from a local ripple
    for (genvar n = 0; n < CHUNK / NIBBLE; n++) begin : g_nib
        logic [NIBBLE-1:0] w_p, w_g, w_k;
        assign w_p = w_pb[n*NIBBLE +: NIBBLE];
        assign w_g = w_gb[n*NIBBLE +: NIBBLE];
        assign w_k[0] = w_nc[n];
        assign w_k[1] = w_g[0] | (w_p[0] & w_k[0]);
        assign w_k[2] = w_g[1] | (w_p[1] & w_k[1]);
        assign w_k[3] = w_g[2] | (w_p[2] & w_k[2]);
        assign w_p_nib[n] = &w_p;
        assign w_g_nib[n] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                          | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
        assign w_chunk_sum[n*NIBBLE +: NIBBLE] = w_p ^ w_k;
    end

    cla4_group u_cla (
        .i_p    (w_p_nib),
        .i_g    (w_g_nib),
        .i_c    (r_carry),
        .o_c1   (w_c1),
        .o_c2   (w_c2),
        .o_c3   (w_c3),
        .o_pg   (w_pg),
        .o_gg   (w_gg),
        .o_cout (w_gcout)
    );

    // Chunk-to-chunk carry rebuilt from group P/G; the explicit carry-out feeds the final flags
    assign w_chain = w_gg | (w_pg & r_carry);
    // Carry into the MSB recovered from its sum bit and propagate
    assign w_cmsb  = w_chunk_sum[CHUNK-1] ^ w_pb[CHUNK-1];
    assign w_last  = (r_cnt == C_LAST);

    // Next-state logic; abort beats last-chunk completion
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (i_start) w_next = ST_RUN;
            ST_RUN: begin
                if (i_abort)     w_next = ST_IDLE;
                else if (w_last) w_next = ST_DONE;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // State register with registered busy/done status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == ST_RUN);
            r_done  <= (w_next == ST_DONE);
        end
    end

    // Operand capture, per-chunk result write-back and final flag registration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_a     <= i_a;
                        r_b     <= i_op_sub ? ~i_b : i_b;
                        r_carry <= i_cin;
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    if (!i_abort) begin
                        r_sum   <= w_sum_next;
                        r_carry <= w_chain;
                        r_cnt   <= r_cnt + C_CW'(1);
                        if (w_last) begin
                            r_cout <= w_gcout;
                            r_ovf  <= w_cmsb ^ w_gcout;
                            r_zero <= (w_sum_next == '0);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_sum  = r_sum;
    assign o_cout = r_cout;
    assign o_ovf  = r_ovf;
    assign o_zero = r_zero;

endmodule : alu_carry_seq
`default_nettype wire

// File: tb/tb_alu_carry_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_carry_seq
//  Description : Self-checking bench for alu_carry_seq with reference model
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_carry_seq;

    localparam int W       = 32;
    localparam int LATENCY = 2;   // negedges from first busy sample to done

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_start, i_op_sub, i_cin, i_abort;
    logic [W-1:0] i_a, i_b;
    logic         o_busy, o_done, o_cout, o_ovf, o_zero;
    logic [W-1:0] o_sum;

    int n_chk = 0;
    int n_err = 0;

    alu_carry_seq #(.WIDTH(W), .CHUNK(16)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (i_start),
        .i_op_sub (i_op_sub),
        .i_cin    (i_cin),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_abort  (i_abort),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_sum    (o_sum),
        .o_cout   (o_cout),
        .o_ovf    (o_ovf),
        .o_zero   (o_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Plain-arithmetic reference: wide add with inverted B for subtract
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input logic cin, output logic [W-1:0] s, output logic co,
                         output logic ov, output logic z);
        logic [W:0]   full;
        logic [W-1:0] bb;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin};
        s    = full[W-1:0];
        co   = full[W];
        ov   = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
        z    = (s == '0);
    endtask

    task automatic wait_done(input string tag, output int cyc);
        bit seen;
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (o_done) seen = 1;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(LATENCY));
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic sub, input logic cin);
        logic [W-1:0] es;
        logic         ec, eo, ez;
        model(a, b, sub, cin, es, ec, eo, ez);
        chk({tag, "_sum"},  64'(o_sum),  64'(es));
        chk({tag, "_cout"}, 64'(o_cout), 64'(ec));
        chk({tag, "_ovf"},  64'(o_ovf),  64'(eo));
        chk({tag, "_zero"}, 64'(o_zero), 64'(ez));
        chk({tag, "_busy_at_done"}, 64'(o_busy), 64'(0));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic cin);
        int           cyc;
        logic [W-1:0] held;
        @(negedge clk);
        i_a = a; i_b = b; i_op_sub = sub; i_cin = cin; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_a = $urandom; i_b = $urandom;
        chk({tag, "_busy"}, 64'(o_busy), 64'(1));
        wait_done(tag, cyc);
        check_result(tag, a, b, sub, cin);
        held = o_sum;
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(o_done), 64'(0));
        chk({tag, "_sum_held"},   64'(o_sum),  64'(held));
    endtask

    initial begin
        int           cyc;
        int           dones;
        logic [W-1:0] ra, rb;
        logic         rs, rc;

        rst_n = 1'b0; i_start = 1'b0; i_op_sub = 1'b0; i_cin = 1'b0;
        i_abort = 1'b0; i_a = '0; i_b = '0;
        #12;
        chk("rst_busy", 64'(o_busy), 64'(0));
        chk("rst_done", 64'(o_done), 64'(0));
        chk("rst_sum",  64'(o_sum),  64'(0));
        chk("rst_zero", 64'(o_zero), 64'(1));
        chk("rst_cout", 64'(o_cout), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op("add_nc",  32'h0000_1234, 32'h0000_1111, 1'b0, 1'b0);
        run_op("xchunk",  32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_op("allones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        run_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
        run_op("sub_eq",  32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1);
        run_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);

        // Handshake: start held during RUN and DONE is ignored
        @(negedge clk);
        i_a = 32'h1111_2222; i_b = 32'h3333_4444; i_op_sub = 1'b0; i_cin = 1'b0; i_start = 1'b1;
        @(negedge clk);
        i_a = 32'hDEAD_BEEF; i_b = 32'h0BAD_F00D; i_op_sub = 1'b1;
        dones = 0;
        cyc   = 0;
        while (!o_done && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("hs_latency", 64'(cyc), 64'(LATENCY));
        if (o_done) dones++;
        check_result("hs", 32'h1111_2222, 32'h3333_4444, 1'b0, 1'b0);
        i_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (o_done) dones++;
            if (i == 0) chk("hs_idle_after_done", 64'(o_busy), 64'(0));
        end
        chk("hs_one_done", 64'(dones), 64'(1));

        // Start the cycle right after done is accepted
        run_op("b2b_a", 32'h0000_00FF, 32'h0000_0F00, 1'b0, 1'b1);
        @(negedge clk);
        i_a = 32'hFFFF_0000; i_b = 32'h0001_0000; i_op_sub = 1'b0; i_cin = 1'b0; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("b2b_busy", 64'(o_busy), 64'(1));
        wait_done("b2b", cyc);
        check_result("b2b", 32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0);

        // Abort in RUN: busy drops, no done follows
        @(negedge clk);
        i_a = 32'h1234_5678; i_b = 32'h1; i_op_sub = 1'b0; i_cin = 1'b0; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0; i_abort = 1'b1;
        chk("abort_busy_t1", 64'(o_busy), 64'(1));
        @(negedge clk);
        i_abort = 1'b0;
        chk("abort_busy_t2", 64'(o_busy), 64'(0));
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            if (o_done) dones++;
            @(negedge clk);
        end
        chk("abort_no_done", 64'(dones), 64'(0));
        run_op("post_abort", 32'hCAFE_0001, 32'h0000_FFFF, 1'b0, 1'b1);

        // Asynchronous reset mid-RUN
        @(negedge clk);
        i_a = 32'hFFFF_FFFF; i_b = 32'h1; i_op_sub = 1'b0; i_cin = 1'b0; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(o_busy), 64'(0));
        chk("arst_done", 64'(o_done), 64'(0));
        chk("arst_zero", 64'(o_zero), 64'(1));
        chk("arst_sum",  64'(o_sum),  64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (o_done || o_busy) dones++;
        end
        chk("arst_quiet", 64'(dones), 64'(0));

        // Randomized operations
        for (int n = 0; n < 40; n++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: ra = '0;
                1: rb = ra;
                default: ;
            endcase
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            run_op("rnd", ra, rb, rs, rc);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_alu_carry_seq
`default_nettype wire

// File: doc/alu_carry_seq.md
Name: alu_carry_seq

Overview:
- Multi-cycle wide add/subtract sequencer. It processes a WIDTH-bit operation CHUNK bits per clock.
- Within each chunk, one shared 4-nibble carry-lookahead group forms the nibble carries. A registered carry links successive chunks.
- It sits beside the main ALU path and serves long-operand arithmetic (bignum/extended-precision microcode ops) without widening the single-cycle carry chain.

Parameters:
- WIDTH, 32, operand/result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 16, bits processed per cycle; must be 16 (four 4-bit nibbles feed one lookahead group).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request a new operation; sampled only in IDLE.
- op_sub  in  1  0 = A+B+cin, 1 = A+~B+cin.
- cin  in  1  carry-in; subtract without borrow requires cin=1.
- a  in  WIDTH  operand A; captured on accepted start.
- b  in  WIDTH  operand B; captured on accepted start.
- abort  in  1  cancel an operation in progress.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the result is valid.
- sum  out  WIDTH  result; held stable from done until the next accepted start.
- cout  out  1  final carry out of the MSB.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  out  1  sum == 0.

Behaviour:
- Reset (async, reset_n=0) clears the FSM to IDLE and clears busy, done, sum, cout, ovf, the chunk counter and the carry register. zero resets to 1.
- States are IDLE, RUN and DONE.
- IDLE:
  - start=1 captures a and b (b inverted if op_sub) into operand registers and loads the carry register with cin.
  - It also sets counter=0 and goes to RUN. busy rises the next cycle.
- RUN, each cycle for chunk k=counter:
  - For each nibble i, form P_i = AND of per-bit propagates and G_i from per-bit generates, both active-high.
  - Nibble carries are C1 = G0|P0c, C2 = G1|P1G0|P1P0c, C3 = G2|P2G1|P2P1G0|P2P1P0c, where c is the carry register.
  - The group carry is G3|P3G2|P3P2G1|P3P2P1G0|P3P2P1P0c.
  - Chunk sum bits are written to sum[k*CHUNK +: CHUNK]. The group carry goes into the carry register.
  - On the last chunk (counter = WIDTH/CHUNK-1), record the carry into the MSB for ovf and go to DONE. Otherwise increment counter.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - cout, ovf and zero are valid and registered. Then go to IDLE.
- Latency: start accepted at cycle T gives done at T+WIDTH/CHUNK+1. The defaults (32/16) give done at T+3.
- start while busy or in DONE is ignored, not queued.
- start in the same cycle as done is ignored. A new start is accepted the following cycle (IDLE).
- abort in RUN returns to IDLE next cycle without a done pulse. sum/cout/ovf/zero are left undefined-but-stable (partially written); the verifier does not check them. abort in IDLE or DONE has no effect. abort takes priority over last-chunk completion.
- Outputs are all registered; there are no combinational paths from inputs to outputs.
- Reset asserted mid-RUN aborts immediately. The reset values above apply and no done is produced.

Decomposition:
- Shared package alu_seq_pkg holds:
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the NIBBLE=4 constant;
  - a localparam function computing NCHUNK=WIDTH/CHUNK.
- One sub-module, cla4_group: purely combinational. Inputs are 4 nibble P, 4 nibble G and carry-in, all active-high. Outputs are C1..C3, group P and group G, plus group carry-out. It is instantiated once and time-shared across chunks.
- The 4-bit nibble adders live inline in alu_carry_seq.

Test Plan:
- Add, no carry: a=32'h0000_1234, b=32'h0000_1111, op_sub=0, cin=0 -> done at T+3, sum=32'h0000_2345, cout=0, ovf=0, zero=0.
- Cross-chunk carry: a=32'h0000_FFFF, b=32'h0000_0001, cin=0 -> sum=32'h0001_0000, cout=0. Then a=b=32'hFFFF_FFFF, cin=1 -> sum=32'hFFFF_FFFF, cout=1.
- Subtract/overflow: a=32'h8000_0000, b=1, op_sub=1, cin=1 -> sum=32'h7FFF_FFFF, ovf=1, cout=1. Then a=b=32'h5, op_sub=1, cin=1 -> sum=0, zero=1, cout=1.
- Handshake: start pulsed during RUN and in the DONE cycle -> ignored, exactly one done; start one cycle after done -> accepted, busy next cycle.
- Abort: start, then abort at T+1 -> busy drops at T+2 and no done ever appears; a following operation completes correctly.
- Async reset: reset_n low mid-RUN, between clock edges -> busy=0, done=0 and zero=1 immediately; after release, an idle bench sees no done.
